// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM datapath: state encodings and default widths.
// Also used by the PWM control unit.
package pwm_pkg;

    localparam int DT_W_DEFAULT = 8;

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_LO_ON = 3'd1;
    localparam logic [2:0] ST_DT_LH = 3'd2;
    localparam logic [2:0] ST_HI_ON = 3'd3;
    localparam logic [2:0] ST_DT_HL = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    typedef enum logic [2:0] {
        S_OFF   = ST_OFF,
        S_LO_ON = ST_LO_ON,
        S_DT_LH = ST_DT_LH,
        S_HI_ON = ST_HI_ON,
        S_DT_HL = ST_DT_HL,
        S_FAULT = ST_FAULT
    } state_t;

    function automatic logic is_dead(state_t s);
        return (s == S_DT_LH) || (s == S_DT_HL);
    endfunction

endpackage

// File: rtl/pwm_deadtime_gen_if.sv
// Bundle of control inputs and half-bridge drive outputs for pwm_deadtime_gen.
// DEADTIME_FAULT_EN adds the fault/fault_clr/fault_latched signals.
interface pwm_deadtime_gen_if #(parameter int DT_W = pwm_pkg::DT_W_DEFAULT);
    import pwm_pkg::*;

    logic            enable;
    logic            pwm_in;
    logic            dt_load;
    logic [DT_W-1:0] dt_rise_in;
    logic [DT_W-1:0] dt_fall_in;
    logic            out_hi;
    logic            out_lo;
    logic            pulse_drop;
    logic            in_dead;
    state_t          state;
`ifdef DEADTIME_FAULT_EN
    logic            fault;
    logic            fault_clr;
    logic            fault_latched;
`endif

    // There is no valid/ready handshake here: inputs are level signals sampled
    // every rising edge and dt_load is a single-cycle strobe.
    modport master (
        output enable, pwm_in, dt_load, dt_rise_in, dt_fall_in,
`ifdef DEADTIME_FAULT_EN
        output fault, fault_clr,
        input  fault_latched,
`endif
        input  out_hi, out_lo, pulse_drop, in_dead, state
    );

    modport slave (
        input  enable, pwm_in, dt_load, dt_rise_in, dt_fall_in,
`ifdef DEADTIME_FAULT_EN
        input  fault, fault_clr,
        output fault_latched,
`endif
        output out_hi, out_lo, pulse_drop, in_dead, state
    );

endinterface

// File: rtl/deadtime_counter.sv
// Dead-time down counter: load, decrement (saturating at 0), clear and zero flag.
module deadtime_counter #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            load,
    input  logic [DT_W-1:0] load_val,
    input  logic            dec,
    output logic [DT_W-1:0] count,
    output logic            zero
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary half-bridge driver with programmable dead time and pulse swallowing.
// Optional DEADTIME_FAULT_EN adds a latched FAULT state that forces both outputs low.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int DT_W   = 8,
    parameter int DT_RST = 4
) (
    input  logic               clk,
    input  logic               reset,
    pwm_deadtime_gen_if.slave  bus
);

    state_t          state, state_next;
    logic [DT_W-1:0] dt_rise_reg, dt_fall_reg;
    logic [DT_W-1:0] cnt;
    logic            cnt_zero, cnt_load, cnt_dec, cnt_clear;
    logic [DT_W-1:0] cnt_val;
    logic            drop_next;

    deadtime_counter #(.DT_W(DT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_OFF;
        else       state <= state_next;
    end

    // Entering a dead-time state loads N-1 so the state lasts exactly N cycles;
    // N=0 skips the dead-time state and swaps the outputs on one edge.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;
        cnt_clear  = 1'b0;
        drop_next  = 1'b0;
        if (!bus.enable) begin
            state_next = S_OFF;
            cnt_clear  = 1'b1;
        end else begin
            case (state)
                S_OFF, S_LO_ON: begin
                    if (!bus.pwm_in) begin
                        state_next = S_LO_ON;
                    end else if (dt_rise_reg == '0) begin
                        state_next = S_HI_ON;
                    end else begin
                        state_next = S_DT_LH;
                        cnt_load   = 1'b1;
                        cnt_val    = dt_rise_reg - 1'b1;
                    end
                end
                S_DT_LH: begin
                    if (!bus.pwm_in) begin
                        state_next = S_LO_ON;
                        drop_next  = 1'b1;
                        cnt_clear  = 1'b1;
                    end else if (cnt_zero) begin
                        state_next = S_HI_ON;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                S_HI_ON: begin
                    if (bus.pwm_in) begin
                        state_next = S_HI_ON;
                    end else if (dt_fall_reg == '0) begin
                        state_next = S_LO_ON;
                    end else begin
                        state_next = S_DT_HL;
                        cnt_load   = 1'b1;
                        cnt_val    = dt_fall_reg - 1'b1;
                    end
                end
                S_DT_HL: begin
                    if (bus.pwm_in) begin
                        state_next = S_HI_ON;
                        drop_next  = 1'b1;
                        cnt_clear  = 1'b1;
                    end else if (cnt_zero) begin
                        state_next = S_LO_ON;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_next = S_OFF;
                    cnt_clear  = 1'b1;
                end
            endcase
        end
`ifdef DEADTIME_FAULT_EN
        // Fault overrides everything; the latch only releases on a clean clear.
        if (bus.fault || (state == S_FAULT)) begin
            state_next = (!bus.fault && bus.fault_clr) ? S_OFF : S_FAULT;
            cnt_load   = 1'b0;
            cnt_dec    = 1'b0;
            cnt_clear  = 1'b1;
            drop_next  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_hi     <= 1'b0;
            bus.out_lo     <= 1'b0;
            bus.pulse_drop <= 1'b0;
            bus.in_dead    <= 1'b0;
            dt_rise_reg    <= DT_W'(DT_RST);
            dt_fall_reg    <= DT_W'(DT_RST);
        end else begin
            bus.out_hi     <= (state_next == S_HI_ON);
            bus.out_lo     <= (state_next == S_LO_ON);
            bus.pulse_drop <= drop_next;
            bus.in_dead    <= is_dead(state_next);
            if (bus.dt_load) begin
                dt_rise_reg <= bus.dt_rise_in;
                dt_fall_reg <= bus.dt_fall_in;
            end
        end
    end

`ifdef DEADTIME_FAULT_EN
    always_ff @(posedge clk) begin
        if (reset) bus.fault_latched <= 1'b0;
        else       bus.fault_latched <= (state_next == S_FAULT);
    end
`endif

    assign bus.state = state;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: a per-cycle vector table plus hand-written
// sequences for dead-time reload, enable/reset and (DEADTIME_FAULT_EN) fault latch.
module tb_pwm_deadtime_gen;
    import pwm_pkg::*;

    localparam logic [3:0] Z  = 4'b0000;  // {hi, lo, drop, dead}
    localparam logic [3:0] HI = 4'b1000;
    localparam logic [3:0] LO = 4'b0100;
    localparam logic [3:0] LD = 4'b0110;
    localparam logic [3:0] HD = 4'b1010;
    localparam logic [3:0] DT = 4'b0001;

    typedef struct packed {
        logic       en;
        logic       pwm;
        logic       ld;
        logic [7:0] r;
        logic [7:0] f;
        logic [3:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;
    vec_t vecs[$];

    pwm_deadtime_gen_if #(.DT_W(8)) bus ();

    pwm_deadtime_gen #(.DT_W(8), .DT_RST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input logic en, input logic pwm, input logic ld,
                        input logic [7:0] r, input logic [7:0] f);
        bus.enable     = en;
        bus.pwm_in     = pwm;
        bus.dt_load    = ld;
        bus.dt_rise_in = r;
        bus.dt_fall_in = f;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {bus.out_hi, bus.out_lo, bus.pulse_drop, bus.in_dead};
        n_total++;
        if (act === exp && !(bus.out_hi && bus.out_lo)) n_pass++;
        else $display("FAIL %s: got hi/lo/drop/dead=%b expected %b", name, act, exp);
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    function automatic void add(input logic en, input logic pwm, input logic ld,
                                input logic [7:0] r, input logic [7:0] f,
                                input logic [3:0] exp);
        vec_t v;
        v.en = en; v.pwm = pwm; v.ld = ld; v.r = r; v.f = f; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.pwm_in     = 1'b0;
        bus.dt_load    = 1'b0;
        bus.dt_rise_in = '0;
        bus.dt_fall_in = '0;
`ifdef DEADTIME_FAULT_EN
        bus.fault      = 1'b0;
        bus.fault_clr  = 1'b0;
`endif

        // Dead time 3/3: lo drops, 3 dead cycles, hi rises; and the falling side.
        add(1,0,1,3,3,LO); add(1,0,0,0,0,LO);
        add(1,1,0,0,0,DT); add(1,1,0,0,0,DT); add(1,1,0,0,0,DT); add(1,1,0,0,0,HI);
        add(1,1,0,0,0,HI); add(1,1,0,0,0,HI);
        add(1,0,0,0,0,DT); add(1,0,0,0,0,DT); add(1,0,0,0,0,DT); add(1,0,0,0,0,LO);
        // Rise dead time 5, pwm high for only 2 cycles: swallowed, one drop strobe.
        add(1,0,1,5,3,LO); add(1,1,0,0,0,DT); add(1,1,0,0,0,DT);
        add(1,0,0,0,0,LD); add(1,0,0,0,0,LO);
        // Zero dead time: direct swaps, never in_dead.
        add(1,0,1,0,0,LO); add(1,1,0,0,0,HI); add(1,1,0,0,0,HI);
        add(1,0,0,0,0,LO); add(1,1,0,0,0,HI); add(1,0,0,0,0,LO);
        // Abort from DT_HL back to HI_ON.
        add(1,0,1,2,2,LO); add(1,1,0,0,0,DT); add(1,1,0,0,0,DT); add(1,1,0,0,0,HI);
        add(1,0,0,0,0,DT); add(1,1,0,0,0,HD);
        // Abort beats cnt==0 in the same cycle (fall dead time 1).
        add(1,1,1,2,1,HI); add(1,0,0,0,0,DT); add(1,1,0,0,0,HD);
        add(1,0,0,0,0,DT); add(1,0,0,0,0,LO);
        // enable low forces OFF; re-enable with pwm high goes through DT_LH.
        add(0,0,0,0,0,Z); add(0,1,0,0,0,Z);
        add(1,1,0,0,0,DT); add(1,1,0,0,0,DT); add(1,1,0,0,0,HI);
        // dt_load on the DT entry cycle: old fall value 1 still applies.
        add(1,0,1,2,5,DT); add(1,0,0,0,0,LO);

        do_reset();
        chk("reset_outputs", Z);
        chk_bit("reset_state_off", bus.state == S_OFF, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].pwm, vecs[i].ld, vecs[i].r, vecs[i].f);
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Fall dead time reloaded 2->7 in the middle of a DT_HL countdown.
        do_reset();
        step(1,0,1,1,2); chk("reload_lo", LO);
        step(1,1,0,0,0); chk("reload_dtlh", DT);
        step(1,1,0,0,0); chk("reload_hi", HI);
        step(1,0,0,0,0); chk("reload_gap2_a", DT);
        step(1,0,1,1,7); chk("reload_gap2_b", DT);
        step(1,0,0,0,0); chk("reload_gap2_end", LO);
        step(1,1,0,0,0); chk("reload_dtlh2", DT);
        step(1,1,0,0,0); chk("reload_hi2", HI);
        for (int i = 0; i < 7; i++) begin
            step(1,0,0,0,0); chk($sformatf("reload_gap7_%0d", i), DT);
        end
        step(1,0,0,0,0); chk("reload_gap7_end", LO);

        // enable low in HI_ON, then reset in the middle of DT_LH.
        do_reset();
        step(1,0,1,3,3); chk("en_lo", LO);
        for (int i = 0; i < 3; i++) begin
            step(1,1,0,0,0); chk($sformatf("en_dt_%0d", i), DT);
        end
        step(1,1,0,0,0); chk("en_hi", HI);
        step(0,1,0,0,0); chk("en_off", Z);
        step(1,1,0,0,0); chk("rst_dtlh", DT);
        reset = 1'b1;
        step(1,1,0,0,0); chk("rst_mid_dt", Z);
        chk_bit("rst_mid_state", bus.state == S_OFF, 1'b1);
        reset = 1'b0;
        step(1,0,0,0,0); chk("rst_lo", LO);
        for (int i = 0; i < 4; i++) begin
            step(1,1,0,0,0); chk($sformatf("rst_dt4_%0d", i), DT);
        end
        step(1,1,0,0,0); chk("rst_dt4_hi", HI);

`ifdef DEADTIME_FAULT_EN
        do_reset();
        chk_bit("flt_reset_latch", bus.fault_latched, 1'b0);
        step(1,0,1,1,1); chk("flt_lo", LO);
        step(1,1,0,0,0); chk("flt_dt", DT);
        step(1,1,0,0,0); chk("flt_hi", HI);
        bus.fault = 1'b1;
        step(1,1,0,0,0); chk("flt_trip", Z);
        chk_bit("flt_latched", bus.fault_latched, 1'b1);
        bus.fault = 1'b0;
        step(1,1,0,0,0); chk("flt_hold", Z);
        chk_bit("flt_hold_latch", bus.fault_latched, 1'b1);
        bus.fault = 1'b1; bus.fault_clr = 1'b1;
        step(1,1,0,0,0); chk("flt_clr_ignored", Z);
        chk_bit("flt_clr_ignored_latch", bus.fault_latched, 1'b1);
        bus.fault = 1'b0;
        step(1,1,0,0,0); chk("flt_cleared", Z);
        chk_bit("flt_cleared_latch", bus.fault_latched, 1'b0);
        bus.fault_clr = 1'b0;
        step(1,1,0,0,0); chk("flt_resume_dt", DT);
        step(1,1,0,0,0); chk("flt_resume_hi", HI);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
